// File: rtl/decision_ctrl.sv
// Decision/backtrack controller for a DPLL-style solver driving an external boolean stack.
// Optional conflict statistics counter is built when DECISION_STATS_EN is defined.
module decision_ctrl #(
    parameter int NUM_VARS = 16,
    parameter int DEPTH_W  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               stk_push,
    output logic               stk_pop,
    output logic               stk_din,
    input  logic               stk_dout,
    input  logic               stk_full,
    output logic               assign_valid,
    output logic [DEPTH_W-1:0] assign_var,
    output logic               assign_val,
    output logic               eval_req,
    input  logic               eval_done,
    input  logic               eval_conflict,
    output logic               busy,
    output logic               sat,
    output logic               unsat,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [15:0]        conflicts
);

    typedef enum logic [2:0] {
        IDLE, DECIDE, EVAL, POP, POP_WAIT, FLIP, SAT, UNSAT
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(NUM_VARS);

    state_t state, state_nx;
    logic   accept;
    logic   at_max;
    logic   at_zero;
    logic   conflict_seen;

    assign accept        = start && (state == IDLE || state == SAT || state == UNSAT);
    assign at_max        = (depth == DEPTH_MAX);
    assign at_zero       = (depth == '0);
    assign conflict_seen = (state == EVAL) && eval_done && eval_conflict;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, SAT, UNSAT: if (start) state_nx = DECIDE;
            DECIDE: begin
                if (at_max)        state_nx = SAT;
                else if (stk_full) state_nx = UNSAT;
                else               state_nx = EVAL;
            end
            EVAL: if (eval_done) state_nx = eval_conflict ? POP : DECIDE;
            // Exhaustion is judged from depth alone; the stack's empty flag is not trusted.
            POP:      state_nx = at_zero ? UNSAT : POP_WAIT;
            POP_WAIT: state_nx = stk_dout ? POP : FLIP;
            FLIP:     state_nx = EVAL;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_din      = 1'b0;
        assign_valid = 1'b0;
        assign_var   = '0;
        assign_val   = 1'b0;
        eval_req     = 1'b0;
        busy         = !(state == IDLE || state == SAT || state == UNSAT);
        sat          = (state == SAT);
        unsat        = (state == UNSAT);
        case (state)
            DECIDE: begin
                if (!at_max && !stk_full) begin
                    stk_push     = 1'b1;
                    assign_valid = 1'b1;
                    assign_var   = depth;
                end
            end
            EVAL: eval_req = 1'b1;
            POP:  stk_pop  = !at_zero;
            FLIP: begin
                stk_push     = 1'b1;
                stk_din      = 1'b1;
                assign_valid = 1'b1;
                assign_var   = depth;
                assign_val   = 1'b1;
            end
            default: ;
        endcase
    end

    // Depth moves only with an actual push or pop, and is clamped at both ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            depth <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            depth <= '0;
            err   <= 1'b0;
        end else begin
            if (state == DECIDE && !at_max && stk_full) err <= 1'b1;
            if (stk_push && !at_max)                    depth <= depth + 1'b1;
            else if (stk_pop && !at_zero)               depth <= depth - 1'b1;
        end
    end

`ifdef DECISION_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                    conflicts <= '0;
        else if (accept)                               conflicts <= '0;
        else if (conflict_seen && conflicts != 16'hFFFF) conflicts <= conflicts + 16'd1;
    end
`else
    assign conflicts = '0;
    logic unused_stats;
    assign unused_stats = conflict_seen;
`endif

endmodule

// File: tb/tb_decision_ctrl.sv
// Directed bench for decision_ctrl with NUM_VARS=3: decide-only, single backtrack,
// full exhaustion, mid-solve reset and stack-full error, checked cycle by cycle.
module tb_decision_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_din;
    logic        stk_dout;
    logic        stk_full;
    logic        assign_valid;
    logic [4:0]  assign_var;
    logic        assign_val;
    logic        eval_req;
    logic        eval_done;
    logic        eval_conflict;
    logic        busy;
    logic        sat;
    logic        unsat;
    logic        err;
    logic [4:0]  depth;
    logic [15:0] conflicts;

    int checks = 0;
    int errors = 0;

`ifdef DECISION_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    decision_ctrl #(.NUM_VARS(3), .DEPTH_W(5)) dut (
        .clock(clock), .reset(reset), .start(start),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_full(stk_full),
        .assign_valid(assign_valid), .assign_var(assign_var), .assign_val(assign_val),
        .eval_req(eval_req), .eval_done(eval_done), .eval_conflict(eval_conflict),
        .busy(busy), .sat(sat), .unsat(unsat), .err(err),
        .depth(depth), .conflicts(conflicts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [19:0] obs;
    assign obs = {stk_push, stk_pop, stk_din, assign_valid, assign_var, assign_val,
                  eval_req, busy, sat, unsat, err, depth};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Field order: push pop din avalid avar aval ereq busy sat unsat err depth
    task automatic expv(input string tag, input logic p, input logic po, input logic d,
                        input logic av, input logic [4:0] v, input logic vl, input logic er,
                        input logic b, input logic s, input logic u, input logic e,
                        input logic [4:0] dp);
        chk(tag, {12'h0, obs}, {12'h0, p, po, d, av, v, vl, er, b, s, u, e, dp});
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic done_ok;
        eval_done = 1'b1; eval_conflict = 1'b0;
        tick();
        eval_done = 1'b0;
    endtask

    task automatic done_conf;
        eval_done = 1'b1; eval_conflict = 1'b1;
        tick();
        eval_done = 1'b0; eval_conflict = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stk_dout = 1'b0; stk_full = 1'b0;
        eval_done = 1'b0; eval_conflict = 1'b0;
        #2;
        expv("rst_outs", 0,0,0,0,0,0,0,0,0,0,0,0);
        chk("rst_conflicts", 32'(conflicts), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        expv("idle", 0,0,0,0,0,0,0,0,0,0,0,0);

        // No conflicts: three decisions at value 0, then SAT
        start = 1'b1; tick(); start = 1'b0;
        expv("s1_dec0",  1,0,0,1,0,0,0,1,0,0,0,0);
        tick();
        expv("s1_eval1", 0,0,0,0,0,0,1,1,0,0,0,1);
        done_ok();
        expv("s1_dec1",  1,0,0,1,1,0,0,1,0,0,0,1);
        tick();
        expv("s1_eval2", 0,0,0,0,0,0,1,1,0,0,0,2);
        done_ok();
        expv("s1_dec2",  1,0,0,1,2,0,0,1,0,0,0,2);
        tick();
        expv("s1_eval3", 0,0,0,0,0,0,1,1,0,0,0,3);
        done_ok();
        expv("s1_dec3",  0,0,0,0,0,0,0,1,0,0,0,3);
        tick();
        expv("s1_sat",   0,0,0,0,0,0,0,0,1,0,0,3);
        tick();
        expv("s1_hold",  0,0,0,0,0,0,0,0,1,0,0,3);

        // First evaluation conflicts, flip to 1, then completes
        start = 1'b1; tick(); start = 1'b0;
        expv("s2_dec0",  1,0,0,1,0,0,0,1,0,0,0,0);
        tick();
        expv("s2_eval1", 0,0,0,0,0,0,1,1,0,0,0,1);
        done_conf();
        expv("s2_pop",   0,1,0,0,0,0,0,1,0,0,0,1);
        stk_dout = 1'b0;
        tick();
        expv("s2_pwait", 0,0,0,0,0,0,0,1,0,0,0,0);
        tick();
        expv("s2_flip",  1,0,1,1,0,1,0,1,0,0,0,0);
        tick();
        expv("s2_evalf", 0,0,0,0,0,0,1,1,0,0,0,1);
        done_ok();
        expv("s2_dec1",  1,0,0,1,1,0,0,1,0,0,0,1);
        tick();
        done_ok();
        expv("s2_dec2",  1,0,0,1,2,0,0,1,0,0,0,2);
        tick();
        done_ok();
        expv("s2_dec3",  0,0,0,0,0,0,0,1,0,0,0,3);
        tick();
        expv("s2_sat",   0,0,0,0,0,0,0,0,1,0,0,3);
        chk("s2_conflicts", 32'(conflicts), 32'(STATS * 1));

        // Every evaluation conflicts: both values of var 0 fail -> UNSAT
        start = 1'b1; tick(); start = 1'b0;
        expv("s3_dec0",  1,0,0,1,0,0,0,1,0,0,0,0);
        tick();
        done_conf();
        expv("s3_pop1",  0,1,0,0,0,0,0,1,0,0,0,1);
        stk_dout = 1'b0;
        tick();
        expv("s3_pw1",   0,0,0,0,0,0,0,1,0,0,0,0);
        tick();
        expv("s3_flip",  1,0,1,1,0,1,0,1,0,0,0,0);
        tick();
        expv("s3_evalf", 0,0,0,0,0,0,1,1,0,0,0,1);
        done_conf();
        expv("s3_pop2",  0,1,0,0,0,0,0,1,0,0,0,1);
        stk_dout = 1'b1;
        tick();
        expv("s3_pw2",   0,0,0,0,0,0,0,1,0,0,0,0);
        tick();
        expv("s3_pop0",  0,0,0,0,0,0,0,1,0,0,0,0);
        tick();
        expv("s3_unsat", 0,0,0,0,0,0,0,0,0,1,0,0);
        chk("s3_conflicts", 32'(conflicts), 32'(STATS * 2));
        stk_dout = 1'b0;

        // Reset asserted in EVAL at depth 2
        start = 1'b1; tick(); start = 1'b0;
        expv("s4_dec0",  1,0,0,1,0,0,0,1,0,0,0,0);
        tick();
        done_ok();
        expv("s4_dec1",  1,0,0,1,1,0,0,1,0,0,0,1);
        tick();
        expv("s4_eval2", 0,0,0,0,0,0,1,1,0,0,0,2);
        reset = 1'b0;
        #1;
        expv("s4_rst_now", 0,0,0,0,0,0,0,0,0,0,0,0);
        chk("s4_rst_conflicts", 32'(conflicts), 32'd0);
        tick();
        expv("s4_rst_hold", 0,0,0,0,0,0,0,0,0,0,0,0);
        reset = 1'b1;
        tick();
        expv("s4_idle1", 0,0,0,0,0,0,0,0,0,0,0,0);
        tick();
        expv("s4_idle2", 0,0,0,0,0,0,0,0,0,0,0,0);

        // Stack full in DECIDE -> UNSAT with err, no push
        stk_full = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        expv("s5_dec_full", 0,0,0,0,0,0,0,1,0,0,0,0);
        tick();
        stk_full = 1'b0;
        expv("s5_unsat_err", 0,0,0,0,0,0,0,0,0,1,1,0);

        // start held high through EVAL is ignored
        start = 1'b1; tick();
        expv("s5_dec0",  1,0,0,1,0,0,0,1,0,0,0,0);
        tick();
        expv("s5_eval_a", 0,0,0,0,0,0,1,1,0,0,0,1);
        tick();
        expv("s5_eval_b", 0,0,0,0,0,0,1,1,0,0,0,1);
        start = 1'b0;
        done_ok();
        expv("s5_dec1",  1,0,0,1,1,0,0,1,0,0,0,1);

        // eval_done in IDLE is ignored
        reset = 1'b0;
        #1;
        expv("s5_rst", 0,0,0,0,0,0,0,0,0,0,0,0);
        tick();
        reset = 1'b1;
        tick();
        done_conf();
        expv("s5_idle_done", 0,0,0,0,0,0,0,0,0,0,0,0);
        chk("s5_idle_conflicts", 32'(conflicts), 32'd0);
        tick();
        expv("s5_idle_after", 0,0,0,0,0,0,0,0,0,0,0,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decision_ctrl.md
DECISION_CTRL -- requirements
Module: decision_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_VARS, default 16, giving the number of variables decided per solve.
REQ-002 The block SHALL have parameter DEPTH_W, default 5, giving the depth counter width; the constraint is 2^DEPTH_W > NUM_VARS.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a solve request sampled in IDLE, SAT or UNSAT.
REQ-006 The block SHALL have port stk_push, output, 1, wired to the boolean stack's write enable.
REQ-007 The block SHALL have port stk_pop, output, 1, wired to the boolean stack's pop.
REQ-008 The block SHALL have port stk_din, output, 1, the value pushed.
REQ-009 The block SHALL have port stk_dout, input, 1, the popped value, valid the cycle after stk_pop.
REQ-010 The block SHALL have port stk_full, input, 1, the stack-full flag.
REQ-011 The block SHALL have port assign_valid, output, 1, a one-cycle pulse announcing an assignment.
REQ-012 The block SHALL have port assign_var, output, DEPTH_W, the index of the variable assigned.
REQ-013 The block SHALL have port assign_val, output, 1, the value assigned.
REQ-014 The block SHALL have port eval_req, output, 1, held high until eval_done.
REQ-015 The block SHALL have port eval_done, input, 1, evaluator completion.
REQ-016 The block SHALL have port eval_conflict, input, 1, the conflict result; it is valid only with eval_done.
REQ-017 The block SHALL have outputs busy, sat, unsat and err, 1 bit each, giving status.
REQ-018 The block SHALL have output depth, DEPTH_W, the current decision depth.
REQ-019 The block SHALL have output conflicts, 16 bits, the conflict count (see Configuration).

Function
REQ-020 The FSM SHALL have the states IDLE, DECIDE, EVAL, POP, POP_WAIT, FLIP, SAT and UNSAT.
REQ-021 From IDLE, SAT or UNSAT, start=1 SHALL move the FSM to DECIDE next cycle, clear depth, sat, unsat and err, and set busy=1.
REQ-022 In DECIDE with depth==NUM_VARS, the FSM SHALL go to SAT with no push.
REQ-023 In DECIDE with stk_full=1, the FSM SHALL go to UNSAT with err=1 and no push.
REQ-024 Otherwise DECIDE SHALL, in one cycle, assert stk_push=1, stk_din=0, assign_valid=1, assign_var=depth and assign_val=0, then set depth to depth+1 and go to EVAL.
REQ-025 EVAL SHALL hold eval_req=1; on eval_done=1 it SHALL go to POP if eval_conflict=1, else to DECIDE, and eval_req SHALL drop the following cycle.
REQ-026 POP with depth==0 SHALL go to UNSAT with no stack pop; exhaustion is detected from depth, never from the stack empty flag.
REQ-027 Otherwise POP SHALL assert stk_pop=1 for one cycle, set depth to depth-1 and go to POP_WAIT.
REQ-028 POP_WAIT SHALL sample stk_dout: 0 (alternative untried) goes to FLIP, and 1 (both values tried) goes to POP.
REQ-029 FLIP SHALL assert stk_push=1, stk_din=1, assign_valid=1, assign_var=depth and assign_val=1 for one cycle, then set depth to depth+1 and go to EVAL.
REQ-030 stk_push and stk_pop SHALL never be high in the same cycle, and each SHALL be high at most one cycle per state visit.
REQ-031 In SAT, sat=1 and busy=0 SHALL hold until start; the same SHALL apply to unsat=1 in UNSAT.
REQ-032 The block SHALL ignore start while busy=1.
REQ-033 The block SHALL ignore eval_done outside EVAL.
REQ-034 The depth counter SHALL never wrap: it is not decremented at 0 and not incremented at NUM_VARS.

Reset
REQ-035 When reset=0, the block SHALL immediately force IDLE and depth=0, with all outputs 0 except conflicts=0.
REQ-036 A reset mid-solve SHALL abandon the solve; the boolean stack is reset by the same event and no stack operation is issued until start.

Configuration
REQ-037 With DECISION_STATS_EN defined, conflicts SHALL increment by 1 on every eval_done with eval_conflict=1, saturate at 16'hFFFF, and clear on accepted start.
REQ-038 Without DECISION_STATS_EN, conflicts SHALL be constant 0 and no counter SHALL be built.

Verification
REQ-039 With NUM_VARS=3 and the evaluator never reporting conflict, the bench SHALL see pushes 0,0,0, assignments (0,0), (1,0), (2,0), then sat=1, depth=3 and no pops.
REQ-040 With NUM_VARS=3 and only the first evaluation conflicting, the bench SHALL see push 0, pop, stk_dout=0, flip push 1 with assignment (0,1), then (1,0), (2,0) and sat=1.
REQ-041 With NUM_VARS=3 and every evaluation conflicting, the bench SHALL see (0,0), a pop, (0,1), a pop returning 1, depth=0, then unsat=1, err=0 and conflicts=2 with DECISION_STATS_EN.
REQ-042 With reset=0 asserted in EVAL at depth 2, all outputs SHALL go to 0 and depth to 0 immediately, and no push or pop SHALL occur until start.
REQ-043 With stk_full=1 forced in DECIDE, the bench SHALL see unsat=1, err=1 and no stk_push; start=1 held during EVAL and eval_done pulsed in IDLE SHALL both have no effect.
